// File: rtl/eth_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : eth_tx_arb
//  Purpose  : Two-requester AXI-Stream packet arbiter feeding a 10G MAC TX,
//             with per-requester forwarded-packet counters.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arb #(
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk156,
    input  logic             sys_rst,
    input  logic             s0_axis_tvalid,
    output logic             s0_axis_tready,
    input  logic [63:0]      s0_axis_tdata,
    input  logic [7:0]       s0_axis_tkeep,
    input  logic             s0_axis_tlast,
    input  logic             s0_axis_tuser,
    input  logic             s1_axis_tvalid,
    output logic             s1_axis_tready,
    input  logic [63:0]      s1_axis_tdata,
    input  logic [7:0]       s1_axis_tkeep,
    input  logic             s1_axis_tlast,
    input  logic             s1_axis_tuser,
    input  logic             m_axis_tready,
    output logic             m_axis_tvalid,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic c_fixed_prio = (ARB_MODE == 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_served;
    logic [CNT_W-1:0] r_pkt_cnt0;
    logic [CNT_W-1:0] r_pkt_cnt1;
    logic             w_pkt_done;

    // The data path is a pure mux selected by state; nothing is registered.
    always_comb begin
        w_state_nxt    = r_state;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        grant          = 2'b00;
        case (r_state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    // Round-robin hands the bus to whoever was not served last.
                    if (c_fixed_prio || r_last_served) begin
                        w_state_nxt = GNT0;
                    end else begin
                        w_state_nxt = GNT1;
                    end
                end else if (s0_axis_tvalid) begin
                    w_state_nxt = GNT0;
                end else if (s1_axis_tvalid) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tuser   = s0_axis_tuser;
                s0_axis_tready = m_axis_tready;
                grant          = 2'b01;
                if (s0_axis_tvalid && m_axis_tready && s0_axis_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            GNT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tuser   = s1_axis_tuser;
                s1_axis_tready = m_axis_tready;
                grant          = 2'b10;
                if (s1_axis_tvalid && m_axis_tready && s1_axis_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_pkt_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk156 or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
            r_pkt_cnt0    <= '0;
            r_pkt_cnt1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pkt_done) begin
                if (r_state == GNT0) begin
                    r_last_served <= 1'b0;
                    r_pkt_cnt0    <= r_pkt_cnt0 + CNT_W'(1);
                end else begin
                    r_last_served <= 1'b1;
                    r_pkt_cnt1    <= r_pkt_cnt1 + CNT_W'(1);
                end
            end
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_tx_arb
//  Purpose  : Self-checking bench for eth_tx_arb (round-robin/CNT_W=4 and
//             fixed-priority/CNT_W=16 instances) against a packet-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arb;

    localparam int c_RR_CNT_W = 4;
    localparam int c_TIMEOUT  = 2000;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic        gap;
    } beat_t;

    logic        clk156 = 1'b0;
    logic        sys_rst;
    // Source index = 2*dut + requester; dut 0 = round-robin, dut 1 = fixed priority.
    logic        sv[4];
    logic        sr[4];
    logic [63:0] sd[4];
    logic [7:0]  sk[4];
    logic        sl[4];
    logic        su[4];
    logic        mv[2];
    logic        mr[2];
    logic [63:0] md[2];
    logic [7:0]  mk[2];
    logic        ml[2];
    logic        mu[2];
    logic [1:0]  g[2];
    logic [c_RR_CNT_W-1:0] rr_cnt0;
    logic [c_RR_CNT_W-1:0] rr_cnt1;
    logic [15:0] fp_cnt0;
    logic [15:0] fp_cnt1;
    logic [15:0] pc[2][2];

    assign pc[0][0] = 16'(rr_cnt0);
    assign pc[0][1] = 16'(rr_cnt1);
    assign pc[1][0] = fp_cnt0;
    assign pc[1][1] = fp_cnt1;

    always #5 clk156 = ~clk156;

    eth_tx_arb #(.ARB_MODE(0), .CNT_W(c_RR_CNT_W)) u_rr (
        .clk156(clk156), .sys_rst(sys_rst),
        .s0_axis_tvalid(sv[0]), .s0_axis_tready(sr[0]), .s0_axis_tdata(sd[0]),
        .s0_axis_tkeep(sk[0]), .s0_axis_tlast(sl[0]), .s0_axis_tuser(su[0]),
        .s1_axis_tvalid(sv[1]), .s1_axis_tready(sr[1]), .s1_axis_tdata(sd[1]),
        .s1_axis_tkeep(sk[1]), .s1_axis_tlast(sl[1]), .s1_axis_tuser(su[1]),
        .m_axis_tready(mr[0]), .m_axis_tvalid(mv[0]), .m_axis_tdata(md[0]),
        .m_axis_tkeep(mk[0]), .m_axis_tlast(ml[0]), .m_axis_tuser(mu[0]),
        .grant(g[0]), .pkt_cnt0(rr_cnt0), .pkt_cnt1(rr_cnt1)
    );

    eth_tx_arb #(.ARB_MODE(1), .CNT_W(16)) u_fp (
        .clk156(clk156), .sys_rst(sys_rst),
        .s0_axis_tvalid(sv[2]), .s0_axis_tready(sr[2]), .s0_axis_tdata(sd[2]),
        .s0_axis_tkeep(sk[2]), .s0_axis_tlast(sl[2]), .s0_axis_tuser(su[2]),
        .s1_axis_tvalid(sv[3]), .s1_axis_tready(sr[3]), .s1_axis_tdata(sd[3]),
        .s1_axis_tkeep(sk[3]), .s1_axis_tlast(sl[3]), .s1_axis_tuser(su[3]),
        .m_axis_tready(mr[1]), .m_axis_tvalid(mv[1]), .m_axis_tdata(md[1]),
        .m_axis_tkeep(mk[1]), .m_axis_tlast(ml[1]), .m_axis_tuser(mu[1]),
        .grant(g[1]), .pkt_cnt0(fp_cnt0), .pkt_cnt1(fp_cnt1)
    );

    beat_t srcq[4][$];
    logic  pop[4];
    logic  rdy_rand[2];
    int    owner[2];
    int    last_s[2];
    int    cnt[2][2];
    int    tot_acc[2][2];
    int    dut_beats[2];
    int    order[2][$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): actual %0h required %0h", name, d, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout, actual expired required completion", name);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            owner[d]  = -1;
            last_s[d] = 1;
            cnt[d][0] = 0;
            cnt[d][1] = 0;
            order[d].delete();
        end
    endfunction

    function automatic bit drained(input int d);
        return (srcq[2*d].size() == 0) && (srcq[2*d+1].size() == 0) && (owner[d] < 0);
    endfunction

    // Packet-level view: who owns the bus, and what the MAC side must show.
    task automatic check_cycle(input int d);
        int   o;
        int   s0i;
        int   src;
        int   nxt;
        int   mask;
        logic ev;
        s0i  = 2 * d;
        mask = (d == 0) ? ((1 << c_RR_CNT_W) - 1) : 16'hFFFF;
        if (sys_rst) begin
            chk("rst_grant",     d, 64'(g[d]), 64'd0);
            chk("rst_m_tvalid",  d, 64'(mv[d]), 64'd0);
            chk("rst_s0_tready", d, 64'(sr[s0i]), 64'd0);
            chk("rst_s1_tready", d, 64'(sr[s0i+1]), 64'd0);
            chk("rst_pkt_cnt0",  d, 64'(pc[d][0]), 64'd0);
            chk("rst_pkt_cnt1",  d, 64'(pc[d][1]), 64'd0);
            return;
        end
        o   = owner[d];
        src = (o < 0) ? s0i : s0i + o;
        ev  = (o >= 0) ? sv[src] : 1'b0;
        chk("grant", d, 64'(g[d]), (o < 0) ? 64'd0 : ((o == 0) ? 64'd1 : 64'd2));
        chk("m_tvalid", d, 64'(mv[d]), 64'(ev));
        if (ev) begin
            chk("m_tdata", d, md[d], sd[src]);
            chk("m_tkeep", d, 64'(mk[d]), 64'(sk[src]));
            chk("m_tlast", d, 64'(ml[d]), 64'(sl[src]));
            chk("m_tuser", d, 64'(mu[d]), 64'(su[src]));
        end
        chk("s0_tready", d, 64'(sr[s0i]), 64'((o == 0) && mr[d]));
        chk("s1_tready", d, 64'(sr[s0i+1]), 64'((o == 1) && mr[d]));
        chk("pkt_cnt0", d, 64'(pc[d][0]), 64'(cnt[d][0]));
        chk("pkt_cnt1", d, 64'(pc[d][1]), 64'(cnt[d][1]));
        if (mv[d] && mr[d]) dut_beats[d]++;
        if (o < 0) begin
            if (sv[s0i] && sv[s0i+1]) nxt = (d == 1) ? 0 : 1 - last_s[d];
            else if (sv[s0i])         nxt = 0;
            else if (sv[s0i+1])       nxt = 1;
            else                      nxt = -1;
            owner[d] = nxt;
            if (nxt >= 0) order[d].push_back(nxt);
        end else if (ev && mr[d]) begin
            tot_acc[d][o]++;
            if (sl[src]) begin
                cnt[d][o] = (cnt[d][o] + 1) & mask;
                last_s[d] = o;
                owner[d]  = -1;
            end
        end
    endtask

    // Sources present queued beats after each edge; checks run on the falling edge.
    initial begin
        for (int i = 0; i < 4; i++) begin
            sv[i] = 1'b0; sd[i] = '0; sk[i] = '0; sl[i] = 1'b0; su[i] = 1'b0; pop[i] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            mr[d] = 1'b1; dut_beats[d] = 0; tot_acc[d][0] = 0; tot_acc[d][1] = 0;
        end
        model_reset();
        forever begin
            @(posedge clk156);
            #1;
            if (sys_rst) begin
                for (int i = 0; i < 4; i++) srcq[i].delete();
                model_reset();
            end else begin
                for (int i = 0; i < 4; i++) if (pop[i]) void'(srcq[i].pop_front());
            end
            for (int i = 0; i < 4; i++) begin
                if (srcq[i].size() > 0) begin
                    sv[i] = !srcq[i][0].gap;
                    sd[i] = srcq[i][0].data;
                    sk[i] = srcq[i][0].keep;
                    sl[i] = srcq[i][0].last;
                    su[i] = srcq[i][0].user;
                end else begin
                    sv[i] = 1'b0; sd[i] = '0; sk[i] = '0; sl[i] = 1'b0; su[i] = 1'b0;
                end
            end
            for (int d = 0; d < 2; d++) mr[d] = rdy_rand[d] ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk156);
            for (int d = 0; d < 2; d++) check_cycle(d);
            for (int i = 0; i < 4; i++)
                pop[i] = !sys_rst && (srcq[i].size() > 0) && (srcq[i][0].gap || (sv[i] && sr[i]));
        end
    end

    task automatic push_pkt(input int qi, input int pid, input int nb, input bit user,
                            input int gapn);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data = {8'hA5, 8'(qi), 16'(pid), 32'(k)};
            b.keep = (k == nb - 1) ? 8'h0F : 8'hFF;
            b.last = (k == nb - 1);
            b.user = user && (k == nb - 1);
            b.gap  = 1'b0;
            srcq[qi].push_back(b);
            if (gapn > 0 && (k % gapn) == gapn - 1 && k != nb - 1) begin
                b = '0;
                b.gap = 1'b1;
                srcq[qi].push_back(b);
            end
        end
    endtask

    task automatic wait_drain(input int d, output int gaps);
        int cyc;
        bit started;
        cyc = 0; gaps = 0; started = 0;
        while (!drained(d) && cyc < c_TIMEOUT) begin
            @(posedge clk156);
            #2;
            cyc++;
            if (g[d] != 2'b00) started = 1;
            else if (started && !drained(d)) gaps++;
        end
        if (cyc >= c_TIMEOUT) timeout_fail("drain");
    endtask

    task automatic pulse_rst();
        @(posedge clk156);
        #3 sys_rst = 1'b1;
        repeat (2) @(posedge clk156);
        #3 sys_rst = 1'b0;
    endtask

    initial begin
        int gaps;
        int b0;
        int n0;
        int k;
        sys_rst     = 1'b1;
        rdy_rand[0] = 1'b0;
        rdy_rand[1] = 1'b0;
        repeat (3) @(posedge clk156);
        #3 sys_rst = 1'b0;

        // Single 7-beat s0 packet, tuser set on the tail.
        b0 = dut_beats[0];
        push_pkt(0, 1, 7, 1'b1, 0);
        @(posedge clk156); #2;
        chk("t1_cycle0_grant", 0, 64'(g[0]), 64'd0);
        @(posedge clk156); #2;
        chk("t1_cycle1_grant", 0, 64'(g[0]), 64'd1);
        chk("t1_first_beat", 0, md[0], 64'hA500_0001_0000_0000);
        wait_drain(0, gaps);
        chk("t1_beats", 0, 64'(dut_beats[0] - b0), 64'd7);
        chk("t1_pkt_cnt0", 0, 64'(pc[0][0]), 64'd1);
        chk("t1_pkt_cnt1", 0, 64'(pc[0][1]), 64'd0);

        // Both requesters busy, round-robin.
        pulse_rst();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 10 + p, 3, 1'b0, 0);
            push_pkt(1, 20 + p, 2, 1'b0, 0);
        end
        wait_drain(0, gaps);
        chk("t2_num_grants", 0, 64'(order[0].size()), 64'd8);
        for (int p = 0; p < 8 && p < order[0].size(); p++)
            chk("t2_grant_order", 0, 64'(order[0][p]), 64'(p % 2));
        chk("t2_bubbles", 0, 64'(gaps), 64'd7);
        chk("t2_pkt_cnt0", 0, 64'(pc[0][0]), 64'd4);
        chk("t2_pkt_cnt1", 0, 64'(pc[0][1]), 64'd4);

        // Same load on the fixed-priority instance.
        for (int p = 0; p < 4; p++) begin
            push_pkt(2, 30 + p, 3, 1'b0, 0);
            push_pkt(3, 35 + p, 2, 1'b0, 0);
        end
        wait_drain(1, gaps);
        chk("t3_num_grants", 1, 64'(order[1].size()), 64'd8);
        for (int p = 0; p < 8 && p < order[1].size(); p++)
            chk("t3_grant_order", 1, 64'(order[1][p]), (p < 4) ? 64'd0 : 64'd1);
        chk("t3_bubbles", 1, 64'(gaps), 64'd7);
        chk("t3_pkt_cnt0", 1, 64'(pc[1][0]), 64'd4);
        chk("t3_pkt_cnt1", 1, 64'(pc[1][1]), 64'd4);

        // s1 packet with gaps and a jittery MAC ready; s0 arrives mid-packet.
        rdy_rand[0] = 1'b1;
        b0 = dut_beats[0];
        n0 = order[0].size();
        push_pkt(1, 40, 10, 1'b0, 3);
        k = 0;
        while (owner[0] != 1 && k < 100) begin
            @(posedge clk156); #3; k++;
        end
        if (k >= 100) timeout_fail("t4_s1_grant");
        push_pkt(0, 41, 3, 1'b0, 0);
        push_pkt(0, 42, 3, 1'b1, 0);
        wait_drain(0, gaps);
        rdy_rand[0] = 1'b0;
        chk("t4_num_grants", 0, 64'(order[0].size() - n0), 64'd3);
        if (order[0].size() >= n0 + 3) begin
            chk("t4_order_0", 0, 64'(order[0][n0]), 64'd1);
            chk("t4_order_1", 0, 64'(order[0][n0+1]), 64'd0);
            chk("t4_order_2", 0, 64'(order[0][n0+2]), 64'd0);
        end
        chk("t4_beats", 0, 64'(dut_beats[0] - b0), 64'd16);
        chk("t4_pkt_cnt0", 0, 64'(pc[0][0]), 64'd6);
        chk("t4_pkt_cnt1", 0, 64'(pc[0][1]), 64'd5);

        // Reset asserted while beat 3 of a 6-beat s1 packet is on the bus.
        @(posedge clk156); #3;
        b0 = tot_acc[0][1];
        push_pkt(1, 60, 6, 1'b0, 0);
        k = 0;
        while (tot_acc[0][1] < b0 + 2 && k < 200) begin
            @(posedge clk156); k++;
        end
        if (k >= 200) timeout_fail("t6_reach_beat3");
        #2;
        chk("t6_pre_grant", 0, 64'(g[0]), 64'd2);
        chk("t6_pre_beat3", 0, md[0], 64'hA501_003C_0000_0002);
        #1 sys_rst = 1'b1;
        #1;
        chk("t6_async_grant", 0, 64'(g[0]), 64'd0);
        chk("t6_async_m_tvalid", 0, 64'(mv[0]), 64'd0);
        chk("t6_async_s0_tready", 0, 64'(sr[0]), 64'd0);
        chk("t6_async_s1_tready", 0, 64'(sr[1]), 64'd0);
        chk("t6_async_pkt_cnt0", 0, 64'(pc[0][0]), 64'd0);
        chk("t6_async_pkt_cnt1", 0, 64'(pc[0][1]), 64'd0);
        repeat (2) @(posedge clk156);
        #3 sys_rst = 1'b0;
        push_pkt(0, 61, 2, 1'b0, 0);
        push_pkt(1, 62, 2, 1'b0, 0);
        wait_drain(0, gaps);
        chk("t6_num_grants", 0, 64'(order[0].size()), 64'd2);
        if (order[0].size() >= 2) begin
            chk("t6_first_after_rst", 0, 64'(order[0][0]), 64'd0);
            chk("t6_second_after_rst", 0, 64'(order[0][1]), 64'd1);
        end
        chk("t6_pkt_cnt0", 0, 64'(pc[0][0]), 64'd1);
        chk("t6_pkt_cnt1", 0, 64'(pc[0][1]), 64'd1);

        // 17 packets through a 4-bit counter wraps to 1.
        pulse_rst();
        for (int p = 0; p < 17; p++) push_pkt(0, 100 + p, (p % 2) + 1, 1'b0, 0);
        wait_drain(0, gaps);
        chk("t5_num_grants", 0, 64'(order[0].size()), 64'd17);
        chk("t5_pkt_cnt0_wrap", 0, 64'(pc[0][0]), 64'd1);
        chk("t5_pkt_cnt1", 0, 64'(pc[0][1]), 64'd0);

        repeat (2) @(posedge clk156);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
